// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and helpers for the framebuffer scan-out engine.
//   - Framebuffer geometry (160x120 x 3-bit) and RAM address width.
//   - Default 640x480@60 VGA timing and the derived line/frame totals.
//   - fb_addr(): row*160 + col built from shifts so no multiplier is inferred.
package fb_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int FB_AW    = 15;
    localparam int FB_DW    = 3;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    function automatic int timing_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = timing_total(H_VIS_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL = timing_total(V_VIS_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    // row*160 + col == (row<<7) + (row<<5) + col
    function automatic logic [FB_AW-1:0] fb_addr(input logic [FB_AW-1:0] col,
                                                 input logic [FB_AW-1:0] row);
        return (row << 7) + (row << 5) + col;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port pixel RAM.
//   clk   : clock for both ports
//   we    : write enable; wdata lands at waddr on the clock edge
//   re    : read enable; mem[raddr] is registered into rdata
//   rdata : registered read data; a same-edge write to raddr is not seen
//           (the read returns the previous contents)
// Contents are not reset.
module fb_ram
    import fb_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = FB_AW,
    parameter int DW    = FB_DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Both ports in one block with non-blocking updates gives read-old-data
    // on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: 160x120x3 framebuffer with VGA scan-out.
//   clk, resetn          : 50 MHz clock, async active-low reset
//   plot, x, y, colour   : pixel write stream, one write per clk, out-of-range dropped
//   VGA_R/G/B            : each colour bit replicated to 10 bits
//   VGA_HS, VGA_VS       : active-low syncs, aligned with RGB
//   VGA_BLANK_N          : high in the visible area
//   VGA_SYNC_N           : tied low
//   VGA_CLK              : 25 MHz pixel clock, rises mid-way through each output interval
//   frame_start          : one-clk pulse on the pixel tick at (hc,vc) = (0,0)
//   vblank               : vertical counter at or beyond the visible lines
// Pipeline per pixel tick: counters -> address + RAM read -> output register,
// so the pins show the counter position from two pixel ticks earlier.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       frame_start,
    output logic       vblank
);

    localparam int H_TOT = timing_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = timing_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int HC_W  = $clog2(H_TOT);
    localparam int VC_W  = $clog2(V_TOT);

    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(H_TOT - 1);
    localparam logic [HC_W-1:0] HC_VIS   = HC_W'(H_VIS);
    localparam logic [HC_W-1:0] HS_FIRST = HC_W'(H_VIS + H_FP);
    localparam logic [HC_W-1:0] HS_LAST  = HC_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VC_W-1:0] VC_LAST  = VC_W'(V_TOT - 1);
    localparam logic [VC_W-1:0] VC_VIS   = VC_W'(V_VIS);
    localparam logic [VC_W-1:0] VS_FIRST = VC_W'(V_VIS + V_FP);
    localparam logic [VC_W-1:0] VS_LAST  = VC_W'(V_VIS + V_FP + V_SYNC - 1);

    localparam logic [7:0] X_LIM = 8'(FB_W);
    localparam logic [6:0] Y_LIM = 7'(FB_H);

    // stage 0: pixel tick and beam counters
    logic            pix_tick_q, pix_tick_d;
    logic [HC_W-1:0] hc_q, hc_d;
    logic [VC_W-1:0] vc_q, vc_d;

    // stage 1: registered RAM read plus matching control
    logic vis1_q, vis1_d;
    logic hs1_q, hs1_d;
    logic vs1_q, vs1_d;

    // stage 2: pin registers
    logic [2:0] rgb_q, rgb_d;
    logic       hs2_q, hs2_d;
    logic       vs2_q, vs2_d;
    logic       blank_n_q, blank_n_d;
    logic       vga_clk_q, vga_clk_d;

    logic             vis0, hs0_n, vs0_n;
    logic             we, re;
    logic [FB_AW-1:0] waddr, raddr;
    logic [2:0]       rd_data;

    always_comb begin
        pix_tick_d = ~pix_tick_q;
        hc_d       = hc_q;
        vc_d       = vc_q;
        if (pix_tick_q) begin
            if (hc_q == HC_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == VC_LAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    always_comb begin
        vis0  = (hc_q < HC_VIS) && (vc_q < VC_VIS);
        hs0_n = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
        vs0_n = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
        raddr = fb_addr(FB_AW'(hc_q >> 2), FB_AW'(vc_q >> 2));
        re    = pix_tick_q && vis0;
    end

    always_comb begin
        we    = plot && (x < X_LIM) && (y < Y_LIM);
        waddr = fb_addr(FB_AW'(x), FB_AW'(y));
    end

    always_comb begin
        vis1_d    = vis1_q;
        hs1_d     = hs1_q;
        vs1_d     = vs1_q;
        rgb_d     = rgb_q;
        hs2_d     = hs2_q;
        vs2_d     = vs2_q;
        blank_n_d = blank_n_q;
        // Registered inverse of pix_tick: rises one clk after the pins change.
        vga_clk_d = ~pix_tick_q;
        if (pix_tick_q) begin
            vis1_d    = vis0;
            hs1_d     = hs0_n;
            vs1_d     = vs0_n;
            // rd_data is stale outside the visible area, so force black there.
            rgb_d     = vis1_q ? rd_data : 3'b000;
            hs2_d     = hs1_q;
            vs2_d     = vs1_q;
            blank_n_d = vis1_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_tick_q <= 1'b0;
            hc_q       <= '0;
            vc_q       <= '0;
            vis1_q     <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            rgb_q      <= 3'b000;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            blank_n_q  <= 1'b0;
            vga_clk_q  <= 1'b0;
        end else begin
            pix_tick_q <= pix_tick_d;
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            vis1_q     <= vis1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            rgb_q      <= rgb_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            blank_n_q  <= blank_n_d;
            vga_clk_q  <= vga_clk_d;
        end
    end

    fb_ram #(
        .DEPTH (FB_DEPTH),
        .AW    (FB_AW),
        .DW    (FB_DW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (colour),
        .re    (re),
        .raddr (raddr),
        .rdata (rd_data)
    );

    assign VGA_R       = {10{rgb_q[2]}};
    assign VGA_G       = {10{rgb_q[1]}};
    assign VGA_B       = {10{rgb_q[0]}};
    assign VGA_HS      = hs2_q;
    assign VGA_VS      = vs2_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vga_clk_q;
    assign frame_start = pix_tick_q && (hc_q == '0) && (vc_q == '0);
    assign vblank      = (vc_q >= VC_VIS);

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout with a shrunken raster (80x30 pixel ticks per frame)
// so several full frames fit in a short run. The reference model views the
// screen as a sequence of pixel slots: slot m is fetched from the buffer at
// clock edge 2m+2 after reset release (writes on that same edge not yet
// visible) and shown on the pins after edge 2m+4.
module tb_fb_scanout;

    localparam int H_VIS  = 64;
    localparam int H_FP   = 4;
    localparam int H_SYNC = 8;
    localparam int H_BP   = 4;
    localparam int V_VIS  = 24;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 2;
    localparam int HT     = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int PIX_PER_FRAME = HT * VT;
    localparam int FRAME_CLK     = 2 * PIX_PER_FRAME;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       plot = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic [9:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
    logic       frame_start, vblank;

    fb_scanout #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK),
        .frame_start(frame_start), .vblank(vblank)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2:0] mem_model [0:19199];
    logic [2:0] exp_rgb [4];
    int         k_edges = 0;
    int         m_fetch, hc_f, vc_f;
    logic       chk_en = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            k_edges = 0;
        end else begin
            k_edges = k_edges + 1;
            if (k_edges % 2 == 0) begin
                m_fetch = k_edges / 2 - 1;
                hc_f = m_fetch % HT;
                vc_f = (m_fetch / HT) % VT;
                exp_rgb[m_fetch % 4] = (hc_f < H_VIS && vc_f < V_VIS)
                                       ? mem_model[(vc_f / 4) * 160 + hc_f / 4] : 3'b000;
            end
            if (plot && x < 160 && y < 120)
                mem_model[int'(y) * 160 + int'(x)] = colour;
        end
    end

    int         n_pix, idx, hc_e, vc_e, vc_now;
    logic [2:0] c_e;
    logic       hs_e, vs_e, bl_e, fs_e;

    always @(negedge clk) begin
        if (resetn && chk_en) begin
            n_pix  = k_edges / 2;
            idx    = n_pix - 2;
            vc_now = (n_pix / HT) % VT;
            fs_e   = (k_edges % 2 == 1) && (n_pix % PIX_PER_FRAME == 0);
            if (idx < 0) begin
                c_e = 3'b000; hs_e = 1'b1; vs_e = 1'b1; bl_e = 1'b0;
            end else begin
                hc_e = idx % HT;
                vc_e = (idx / HT) % VT;
                c_e  = exp_rgb[idx % 4];
                hs_e = !(hc_e >= H_VIS + H_FP && hc_e < H_VIS + H_FP + H_SYNC);
                vs_e = !(vc_e >= V_VIS + V_FP && vc_e < V_VIS + V_FP + V_SYNC);
                bl_e = (hc_e < H_VIS) && (vc_e < V_VIS);
            end
            check_val("rgb", {VGA_R, VGA_G, VGA_B},
                      {{10{c_e[2]}}, {10{c_e[1]}}, {10{c_e[0]}}});
            check_val("ctl", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start, vblank},
                      {hs_e, vs_e, bl_e, 1'b0, logic'(k_edges % 2), fs_e, logic'(vc_now >= V_VIS)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic plot_px(input int px, input int py, input logic [2:0] c);
        @(negedge clk);
        plot = 1'b1; x = 8'(px); y = 7'(py); colour = c;
        @(negedge clk);
        plot = 1'b0;
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return VGA_HS;
            1:       return VGA_VS;
            default: return ~frame_start;
        endcase
    endfunction

    // Measures low width and fall-to-fall period of an active-low signal.
    task automatic meas(input int sel, input string tag, input int exp_low, input int exp_per);
        int   cyc, f1, r1, f2;
        logic prev, cur;
        cyc = 0; f1 = -1; r1 = -1; f2 = -1;
        @(negedge clk);
        prev = sig_sel(sel);
        while (f2 < 0 && cyc < 3 * FRAME_CLK) begin
            @(negedge clk);
            cyc++;
            cur = sig_sel(sel);
            if (prev && !cur) begin
                if (f1 < 0) f1 = cyc;
                else if (r1 >= 0) f2 = cyc;
            end
            if (!prev && cur && f1 >= 0 && r1 < 0) r1 = cyc;
            prev = cur;
        end
        check_val({tag, "_found"}, (f2 >= 0), 1'b1);
        if (f2 >= 0) begin
            check_val({tag, "_low"}, 64'(r1 - f1), 64'(exp_low));
            check_val({tag, "_per"}, 64'(f2 - f1), 64'(exp_per));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   tgt, cnt;
        logic found;

        for (int i = 0; i < 19200; i++) mem_model[i] = 3'b000;
        for (int i = 0; i < 4; i++) exp_rgb[i] = 3'b000;

        repeat (3) @(negedge clk);
        resetn = 1'b1;
        chk_en = 1'b1;

        // reset in the middle of a line
        repeat (500) @(negedge clk);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check_val("rst_rgb", {VGA_R, VGA_G, VGA_B}, 30'd0);
        check_val("rst_ctl", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start, vblank},
                  7'b1100000);
        repeat (2) @(negedge clk);
        check_val("rst_hold", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK, frame_start}, 5'b11000);
        resetn = 1'b1;

        // single pixel, then bounds
        plot_px(5, 3, 3'b101);
        repeat (FRAME_CLK + 100) @(negedge clk);
        plot_px(160, 0, 3'b111);
        plot_px(0, 120, 3'b111);
        plot_px(159, 119, 3'b111);
        repeat (FRAME_CLK + 100) @(negedge clk);

        // collision: write block (2,1) on the edge that fetches its last replica
        plot_px(2, 1, 3'b011);
        tgt = 2 * (((k_edges / 2) / PIX_PER_FRAME + 1) * PIX_PER_FRAME + 7 * HT + 11) + 2;
        found = 1'b0;
        cnt = 0;
        while (!found && cnt < 3 * FRAME_CLK) begin
            if (k_edges == tgt - 1) found = 1'b1;
            else begin
                @(negedge clk);
                cnt++;
            end
        end
        check_val("coll_sync", found, 1'b1);
        plot = 1'b1; x = 8'd2; y = 7'd1; colour = 3'b100;
        @(negedge clk);
        plot = 1'b0;
        repeat (2 * FRAME_CLK + 100) @(negedge clk);

        // burst: fill row 0 back-to-back
        @(negedge clk);
        for (int i = 0; i < 160; i++) begin
            plot = 1'b1; x = 8'(i); y = 7'd0; colour = 3'b010;
            @(negedge clk);
        end
        plot = 1'b0;
        repeat (FRAME_CLK + 100) @(negedge clk);

        // random writes, mostly into the visible window, some out of range
        for (int i = 0; i < 400; i++) begin
            plot   = 1'($urandom_range(0, 1));
            x      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 200)) : 8'($urandom_range(0, 17));
            y      = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(115, 127)) : 7'($urandom_range(0, 7));
            colour = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        plot = 1'b0;
        repeat (FRAME_CLK + 100) @(negedge clk);

        // sync and frame timing
        meas(0, "hs", 2 * H_SYNC, 2 * HT);
        meas(1, "vs", 2 * V_SYNC * HT, FRAME_CLK);
        meas(2, "frame_start", 1, FRAME_CLK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
